// File: rtl/arm7tdmi_decode.sv
// ARM7TDMI decode stage: classifies one ARM or Thumb instruction per cycle
// and registers the extracted operand fields with one cycle of latency.

package arm7tdmi_pkg;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } condition_t;

    typedef enum logic [3:0] {
        INSTR_DATA_PROC, INSTR_PSR_TRANSFER, INSTR_MUL, INSTR_MUL_LONG,
        INSTR_SINGLE_SWAP, INSTR_BRANCH_EX, INSTR_HALFWORD_DT, INSTR_SINGLE_DT,
        INSTR_BLOCK_DT, INSTR_BRANCH, INSTR_COPROCESSOR, INSTR_SWI
    } instr_type_t;

    typedef enum logic [3:0] {
        ALU_AND, ALU_EOR, ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC, ALU_SBC, ALU_RSC,
        ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN, ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN
    } alu_op_t;

    typedef enum logic [1:0] {
        SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR
    } shift_type_t;

    typedef enum logic [2:0] {
        CP_CDP, CP_MCR, CP_MRC, CP_LDC, CP_STC
    } cp_op_t;

    typedef enum logic [4:0] {
        THUMB_SHIFT, THUMB_ALU_IMM, THUMB_CMP_MOV_IMM, THUMB_ALU_REG,
        THUMB_ALU_HI, THUMB_PC_REL_LOAD, THUMB_LOAD_STORE_REG,
        THUMB_LOAD_STORE_IMM, THUMB_LOAD_STORE_HW, THUMB_LOAD_STORE_SP,
        THUMB_GET_REL_ADDR, THUMB_ADD_SP, THUMB_PUSH_POP,
        THUMB_LOAD_STORE_MULT, THUMB_SWI, THUMB_BRANCH_COND,
        THUMB_BRANCH_UNCOND, THUMB_BL_HIGH, THUMB_BL_LOW, THUMB_UNDEFINED
    } thumb_instr_type_t;

    typedef struct packed {
        condition_t        condition;
        instr_type_t       instr_type;
        alu_op_t           alu_op;
        logic [3:0]        rd;
        logic [3:0]        rn;
        logic [3:0]        rm;
        logic [11:0]       immediate;
        logic              imm_en;
        logic              set_flags;
        shift_type_t       shift_type;
        logic [4:0]        shift_amount;
        logic              shift_reg;
        logic [3:0]        shift_rs;
        logic              is_branch;
        logic              branch_link;
        logic [23:0]       branch_offset;
        logic              is_memory;
        logic              mem_load;
        logic              mem_byte;
        logic              mem_pre;
        logic              mem_up;
        logic              mem_writeback;
        logic              psr_to_reg;
        logic              psr_spsr;
        logic              psr_immediate;
        cp_op_t            cp_op;
        logic [3:0]        cp_num;
        logic [3:0]        cp_rd;
        logic [3:0]        cp_rn;
        logic [2:0]        cp_opcode1;
        logic [2:0]        cp_opcode2;
        logic              cp_load;
        thumb_instr_type_t thumb_instr_type;
        logic [2:0]        thumb_rd;
        logic [2:0]        thumb_rs;
        logic [2:0]        thumb_rn;
        logic [7:0]        thumb_imm8;
        logic [7:0]        thumb_offset8;
        logic [4:0]        thumb_imm5;
        logic [10:0]       thumb_offset11;
    } decode_t;

endpackage

module arm7tdmi_decode
    import arm7tdmi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_in,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              thumb_mode,
    output condition_t        condition,
    output instr_type_t       instr_type,
    output alu_op_t           alu_op,
    output logic [3:0]        rd,
    output logic [3:0]        rn,
    output logic [3:0]        rm,
    output logic [11:0]       immediate,
    output logic              imm_en,
    output logic              set_flags,
    output shift_type_t       shift_type,
    output logic [4:0]        shift_amount,
    output logic              shift_reg,
    output logic [3:0]        shift_rs,
    output logic              is_branch,
    output logic              branch_link,
    output logic [23:0]       branch_offset,
    output logic              is_memory,
    output logic              mem_load,
    output logic              mem_byte,
    output logic              mem_pre,
    output logic              mem_up,
    output logic              mem_writeback,
    output logic              psr_to_reg,
    output logic              psr_spsr,
    output logic              psr_immediate,
    output cp_op_t            cp_op,
    output logic [3:0]        cp_num,
    output logic [3:0]        cp_rd,
    output logic [3:0]        cp_rn,
    output logic [2:0]        cp_opcode1,
    output logic [2:0]        cp_opcode2,
    output logic              cp_load,
    output thumb_instr_type_t thumb_instr_type,
    output logic [2:0]        thumb_rd,
    output logic [2:0]        thumb_rs,
    output logic [2:0]        thumb_rn,
    output logic [7:0]        thumb_imm8,
    output logic [7:0]        thumb_offset8,
    output logic [4:0]        thumb_imm5,
    output logic [10:0]       thumb_offset11,
    output logic [31:0]       pc_out,
    output logic              decode_valid
);

    logic [31:0]       ins;
    logic [15:0]       hw;
    instr_type_t       arm_cls;
    thumb_instr_type_t thm_cls;
    logic              opnd;
    logic              mem;
    decode_t           dec_d;
    decode_t           dec_q;
    logic [31:0]       pc_q;
    logic              valid_q;

    assign ins = instruction;
    assign hw  = instruction[15:0];

    // ARM classes in priority order; the specific encodings sit inside
    // the broader data-processing space and must be matched first.
    always_comb begin
        arm_cls = INSTR_SWI;
        if (ins[27:4] == 24'h12FFF1)
            arm_cls = INSTR_BRANCH_EX;
        else if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001)
            arm_cls = INSTR_MUL;
        else if (ins[27:23] == 5'b00001 && ins[7:4] == 4'b1001)
            arm_cls = INSTR_MUL_LONG;
        else if (ins[27:23] == 5'b00010 && ins[21:20] == 2'b00
                 && ins[11:4] == 8'h09)
            arm_cls = INSTR_SINGLE_SWAP;
        else if (ins[27:25] == 3'b000 && ins[7] && ins[4]
                 && ins[6:5] != 2'b00)
            arm_cls = INSTR_HALFWORD_DT;
        else if (ins[27:26] == 2'b00 && ins[24:23] == 2'b10 && !ins[20])
            arm_cls = INSTR_PSR_TRANSFER;
        else if (ins[27:26] == 2'b00)
            arm_cls = INSTR_DATA_PROC;
        else if (ins[27:26] == 2'b01)
            arm_cls = INSTR_SINGLE_DT;
        else if (ins[27:25] == 3'b100)
            arm_cls = INSTR_BLOCK_DT;
        else if (ins[27:25] == 3'b101)
            arm_cls = INSTR_BRANCH;
        else if (ins[27:25] == 3'b110 || ins[27:24] == 4'b1110)
            arm_cls = INSTR_COPROCESSOR;
    end

    always_comb begin
        thm_cls = THUMB_UNDEFINED;
        if (hw[15:11] == 5'b00011)
            thm_cls = THUMB_ALU_IMM;
        else if (hw[15:13] == 3'b000)
            thm_cls = THUMB_SHIFT;
        else if (hw[15:13] == 3'b001)
            thm_cls = THUMB_CMP_MOV_IMM;
        else if (hw[15:10] == 6'b010000)
            thm_cls = THUMB_ALU_REG;
        else if (hw[15:10] == 6'b010001)
            thm_cls = THUMB_ALU_HI;
        else if (hw[15:11] == 5'b01001)
            thm_cls = THUMB_PC_REL_LOAD;
        else if (hw[15:12] == 4'b0101)
            thm_cls = THUMB_LOAD_STORE_REG;
        else if (hw[15:13] == 3'b011)
            thm_cls = THUMB_LOAD_STORE_IMM;
        else if (hw[15:12] == 4'b1000)
            thm_cls = THUMB_LOAD_STORE_HW;
        else if (hw[15:12] == 4'b1001)
            thm_cls = THUMB_LOAD_STORE_SP;
        else if (hw[15:12] == 4'b1010)
            thm_cls = THUMB_GET_REL_ADDR;
        else if (hw[15:8] == 8'hB0)
            thm_cls = THUMB_ADD_SP;
        else if (hw[15:12] == 4'b1011 && hw[10:9] == 2'b10)
            thm_cls = THUMB_PUSH_POP;
        else if (hw[15:12] == 4'b1100)
            thm_cls = THUMB_LOAD_STORE_MULT;
        else if (hw[15:8] == 8'hDF)
            thm_cls = THUMB_SWI;
        else if (hw[15:12] == 4'b1101)
            thm_cls = THUMB_BRANCH_COND;
        else if (hw[15:11] == 5'b11100)
            thm_cls = THUMB_BRANCH_UNCOND;
        else if (hw[15:11] == 5'b11110)
            thm_cls = THUMB_BL_HIGH;
        else if (hw[15:11] == 5'b11111)
            thm_cls = THUMB_BL_LOW;
    end

    assign opnd = !(arm_cls inside {INSTR_BRANCH, INSTR_COPROCESSOR,
                                    INSTR_SWI});
    assign mem  = arm_cls inside {INSTR_SINGLE_DT, INSTR_BLOCK_DT,
                                  INSTR_HALFWORD_DT, INSTR_SINGLE_SWAP};

    always_comb begin
        dec_d = '0;
        if (!thumb_mode) begin
            dec_d.condition  = condition_t'(ins[31:28]);
            dec_d.instr_type = arm_cls;
            if (opnd) begin
                dec_d.rd           = ins[15:12];
                dec_d.rn           = ins[19:16];
                dec_d.rm           = ins[3:0];
                dec_d.immediate    = ins[11:0];
                dec_d.shift_type   = shift_type_t'(ins[6:5]);
                dec_d.shift_amount = ins[11:7];
                dec_d.shift_reg    = ins[4];
                dec_d.shift_rs     = ins[11:8];
            end
            if (mem) begin
                dec_d.is_memory     = 1'b1;
                dec_d.mem_load      = ins[20];
                dec_d.mem_byte      = ins[22];
                dec_d.mem_pre       = ins[24];
                dec_d.mem_up        = ins[23];
                dec_d.mem_writeback = ins[21];
            end
            unique case (arm_cls)
                INSTR_DATA_PROC: begin
                    dec_d.alu_op    = alu_op_t'(ins[24:21]);
                    dec_d.imm_en    = ins[25];
                    dec_d.set_flags = ins[20];
                end
                INSTR_MUL, INSTR_MUL_LONG: dec_d.set_flags = ins[20];
                INSTR_SINGLE_DT:   dec_d.imm_en = ~ins[25];
                INSTR_HALFWORD_DT: dec_d.imm_en = ins[22];
                INSTR_PSR_TRANSFER: begin
                    dec_d.psr_to_reg    = ~ins[21];
                    dec_d.psr_spsr      = ins[22];
                    dec_d.psr_immediate = ins[25];
                end
                INSTR_BRANCH_EX: dec_d.is_branch = 1'b1;
                INSTR_BRANCH: begin
                    dec_d.is_branch     = 1'b1;
                    dec_d.branch_link   = ins[24];
                    dec_d.branch_offset = ins[23:0];
                end
                INSTR_COPROCESSOR: begin
                    if (ins[27:25] == 3'b110)
                        dec_d.cp_op = ins[20] ? CP_LDC : CP_STC;
                    else if (!ins[4])
                        dec_d.cp_op = CP_CDP;
                    else
                        dec_d.cp_op = ins[20] ? CP_MRC : CP_MCR;
                    dec_d.cp_num     = ins[11:8];
                    dec_d.cp_rd      = ins[15:12];
                    dec_d.cp_rn      = ins[19:16];
                    dec_d.cp_opcode1 = ins[23:21];
                    dec_d.cp_opcode2 = ins[7:5];
                    dec_d.cp_load    = ins[20];
                end
                default: ;
            endcase
        end else begin
            dec_d.thumb_instr_type = thm_cls;
            dec_d.condition = (thm_cls == THUMB_BRANCH_COND)
                            ? condition_t'(hw[11:8]) : COND_AL;
            if (thm_cls inside {THUMB_CMP_MOV_IMM, THUMB_PC_REL_LOAD,
                                THUMB_LOAD_STORE_SP, THUMB_GET_REL_ADDR,
                                THUMB_LOAD_STORE_MULT})
                dec_d.thumb_rd = hw[10:8];
            else
                dec_d.thumb_rd = hw[2:0];
            dec_d.thumb_rs       = hw[5:3];
            dec_d.thumb_rn       = hw[8:6];
            dec_d.thumb_imm8     = hw[7:0];
            dec_d.thumb_offset8  = hw[7:0];
            dec_d.thumb_imm5     = hw[10:6];
            dec_d.thumb_offset11 = hw[10:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dec_q   <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            dec_q   <= dec_d;
            pc_q    <= pc_in;
            valid_q <= instr_valid;
        end
    end

    assign condition        = dec_q.condition;
    assign instr_type       = dec_q.instr_type;
    assign alu_op           = dec_q.alu_op;
    assign rd               = dec_q.rd;
    assign rn               = dec_q.rn;
    assign rm               = dec_q.rm;
    assign immediate        = dec_q.immediate;
    assign imm_en           = dec_q.imm_en;
    assign set_flags        = dec_q.set_flags;
    assign shift_type       = dec_q.shift_type;
    assign shift_amount     = dec_q.shift_amount;
    assign shift_reg        = dec_q.shift_reg;
    assign shift_rs         = dec_q.shift_rs;
    assign is_branch        = dec_q.is_branch;
    assign branch_link      = dec_q.branch_link;
    assign branch_offset    = dec_q.branch_offset;
    assign is_memory        = dec_q.is_memory;
    assign mem_load         = dec_q.mem_load;
    assign mem_byte         = dec_q.mem_byte;
    assign mem_pre          = dec_q.mem_pre;
    assign mem_up           = dec_q.mem_up;
    assign mem_writeback    = dec_q.mem_writeback;
    assign psr_to_reg       = dec_q.psr_to_reg;
    assign psr_spsr         = dec_q.psr_spsr;
    assign psr_immediate    = dec_q.psr_immediate;
    assign cp_op            = dec_q.cp_op;
    assign cp_num           = dec_q.cp_num;
    assign cp_rd            = dec_q.cp_rd;
    assign cp_rn            = dec_q.cp_rn;
    assign cp_opcode1       = dec_q.cp_opcode1;
    assign cp_opcode2       = dec_q.cp_opcode2;
    assign cp_load          = dec_q.cp_load;
    assign thumb_instr_type = dec_q.thumb_instr_type;
    assign thumb_rd         = dec_q.thumb_rd;
    assign thumb_rs         = dec_q.thumb_rs;
    assign thumb_rn         = dec_q.thumb_rn;
    assign thumb_imm8       = dec_q.thumb_imm8;
    assign thumb_offset8    = dec_q.thumb_offset8;
    assign thumb_imm5       = dec_q.thumb_imm5;
    assign thumb_offset11   = dec_q.thumb_offset11;
    assign pc_out           = pc_q;
    assign decode_valid     = valid_q;

endmodule

// File: tb/tb_arm7tdmi_decode.sv
// Scoreboard bench for arm7tdmi_decode: a mask/value reference decoder
// predicts every registered output one cycle after each stimulus.

module tb_arm7tdmi_decode;
    import arm7tdmi_pkg::*;

    typedef enum int {
        F_COND, F_TYPE, F_ALU, F_RD, F_RN, F_RM, F_IMM, F_IMMEN, F_SETF,
        F_SHT, F_SHA, F_SHR, F_SHRS, F_ISB, F_BL, F_BOFF, F_ISM, F_ML,
        F_MB, F_MP, F_MU, F_MW, F_PTR, F_PSP, F_PIM, F_CPOP, F_CPN, F_CPRD,
        F_CPRN, F_CPO1, F_CPO2, F_CPL, F_TTYPE, F_TRD, F_TRS, F_TRN, F_TI8,
        F_TO8, F_TI5, F_TO11, F_PC, F_VALID, NF
    } fld_e;

    typedef logic [NF-1:0][31:0] vec_t;

    string fname [NF] = '{
        "condition", "instr_type", "alu_op", "rd", "rn", "rm", "immediate",
        "imm_en", "set_flags", "shift_type", "shift_amount", "shift_reg",
        "shift_rs", "is_branch", "branch_link", "branch_offset", "is_memory",
        "mem_load", "mem_byte", "mem_pre", "mem_up", "mem_writeback",
        "psr_to_reg", "psr_spsr", "psr_immediate", "cp_op", "cp_num", "cp_rd",
        "cp_rn", "cp_opcode1", "cp_opcode2", "cp_load", "thumb_instr_type",
        "thumb_rd", "thumb_rs", "thumb_rn", "thumb_imm8", "thumb_offset8",
        "thumb_imm5", "thumb_offset11", "pc_out", "decode_valid"
    };

    logic [31:0] arm_vec [14] = '{
        32'hE0820001, 32'hE0000291, 32'hE0800291, 32'hE1010091,
        32'hE1D100F0, 32'hE10F0000, 32'hE129F000, 32'hE12FFF10,
        32'hEB000000, 32'hEF000000, 32'hEE000010, 32'hE5D10000,
        32'hE8910003, 32'hEC900100
    };
    logic [15:0] thm_vec [8] = '{
        16'h0148, 16'h3205, 16'h1888, 16'h4700,
        16'hC800, 16'hD000, 16'hF000, 16'hF800
    };

    logic clk = 1'b0;
    logic rst_n, instr_valid, stall, flush, thumb_mode;
    logic [31:0] instruction, pc_in;
    condition_t        condition;
    instr_type_t       instr_type;
    alu_op_t           alu_op;
    logic [3:0]        rd, rn, rm, shift_rs, cp_num, cp_rd, cp_rn;
    logic [11:0]       immediate;
    logic              imm_en, set_flags, shift_reg, is_branch, branch_link;
    shift_type_t       shift_type;
    logic [4:0]        shift_amount, thumb_imm5;
    logic [23:0]       branch_offset;
    logic              is_memory, mem_load, mem_byte, mem_pre, mem_up;
    logic              mem_writeback, psr_to_reg, psr_spsr, psr_immediate;
    cp_op_t            cp_op;
    logic [2:0]        cp_opcode1, cp_opcode2, thumb_rd, thumb_rs, thumb_rn;
    logic              cp_load, decode_valid;
    thumb_instr_type_t thumb_instr_type;
    logic [7:0]        thumb_imm8, thumb_offset8;
    logic [10:0]       thumb_offset11;
    logic [31:0]       pc_out;

    int   checks = 0;
    int   failures = 0;
    vec_t q [$];
    vec_t st;
    logic [31:0] pc_cnt = 32'h0000_8000;

    always #5 clk = ~clk;

    arm7tdmi_decode dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_in(pc_in),
        .instr_valid(instr_valid), .stall(stall), .flush(flush),
        .thumb_mode(thumb_mode), .condition(condition),
        .instr_type(instr_type), .alu_op(alu_op), .rd(rd), .rn(rn), .rm(rm),
        .immediate(immediate), .imm_en(imm_en), .set_flags(set_flags),
        .shift_type(shift_type), .shift_amount(shift_amount),
        .shift_reg(shift_reg), .shift_rs(shift_rs), .is_branch(is_branch),
        .branch_link(branch_link), .branch_offset(branch_offset),
        .is_memory(is_memory), .mem_load(mem_load), .mem_byte(mem_byte),
        .mem_pre(mem_pre), .mem_up(mem_up), .mem_writeback(mem_writeback),
        .psr_to_reg(psr_to_reg), .psr_spsr(psr_spsr),
        .psr_immediate(psr_immediate), .cp_op(cp_op), .cp_num(cp_num),
        .cp_rd(cp_rd), .cp_rn(cp_rn), .cp_opcode1(cp_opcode1),
        .cp_opcode2(cp_opcode2), .cp_load(cp_load),
        .thumb_instr_type(thumb_instr_type), .thumb_rd(thumb_rd),
        .thumb_rs(thumb_rs), .thumb_rn(thumb_rn), .thumb_imm8(thumb_imm8),
        .thumb_offset8(thumb_offset8), .thumb_imm5(thumb_imm5),
        .thumb_offset11(thumb_offset11), .pc_out(pc_out),
        .decode_valid(decode_valid)
    );

    function automatic logic [31:0] bits(logic [31:0] w, int lo, int n);
        return (w >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic int arm_class(logic [31:0] w);
        if ((w & 32'h0FFFFFF0) == 32'h012FFF10) return INSTR_BRANCH_EX;
        if ((w & 32'h0FC000F0) == 32'h00000090) return INSTR_MUL;
        if ((w & 32'h0F8000F0) == 32'h00800090) return INSTR_MUL_LONG;
        if ((w & 32'h0FB00FF0) == 32'h01000090) return INSTR_SINGLE_SWAP;
        if ((w & 32'h0E000090) == 32'h00000090 && (w & 32'h60) != 0)
            return INSTR_HALFWORD_DT;
        if ((w & 32'h0D900000) == 32'h01000000) return INSTR_PSR_TRANSFER;
        if ((w & 32'h0C000000) == 32'h00000000) return INSTR_DATA_PROC;
        if ((w & 32'h0C000000) == 32'h04000000) return INSTR_SINGLE_DT;
        if ((w & 32'h0E000000) == 32'h08000000) return INSTR_BLOCK_DT;
        if ((w & 32'h0E000000) == 32'h0A000000) return INSTR_BRANCH;
        if ((w & 32'h0E000000) == 32'h0C000000) return INSTR_COPROCESSOR;
        if ((w & 32'h0F000000) == 32'h0E000000) return INSTR_COPROCESSOR;
        return INSTR_SWI;
    endfunction

    function automatic int thumb_class(logic [31:0] h);
        if ((h & 32'hF800) == 32'h1800) return THUMB_ALU_IMM;
        if ((h & 32'hE000) == 32'h0000) return THUMB_SHIFT;
        if ((h & 32'hE000) == 32'h2000) return THUMB_CMP_MOV_IMM;
        if ((h & 32'hFC00) == 32'h4000) return THUMB_ALU_REG;
        if ((h & 32'hFC00) == 32'h4400) return THUMB_ALU_HI;
        if ((h & 32'hF800) == 32'h4800) return THUMB_PC_REL_LOAD;
        if ((h & 32'hF000) == 32'h5000) return THUMB_LOAD_STORE_REG;
        if ((h & 32'hE000) == 32'h6000) return THUMB_LOAD_STORE_IMM;
        if ((h & 32'hF000) == 32'h8000) return THUMB_LOAD_STORE_HW;
        if ((h & 32'hF000) == 32'h9000) return THUMB_LOAD_STORE_SP;
        if ((h & 32'hF000) == 32'hA000) return THUMB_GET_REL_ADDR;
        if ((h & 32'hFF00) == 32'hB000) return THUMB_ADD_SP;
        if ((h & 32'hF600) == 32'hB400) return THUMB_PUSH_POP;
        if ((h & 32'hF000) == 32'hC000) return THUMB_LOAD_STORE_MULT;
        if ((h & 32'hFF00) == 32'hDF00) return THUMB_SWI;
        if ((h & 32'hF000) == 32'hD000) return THUMB_BRANCH_COND;
        if ((h & 32'hF800) == 32'hE000) return THUMB_BRANCH_UNCOND;
        if ((h & 32'hF800) == 32'hF000) return THUMB_BL_HIGH;
        if ((h & 32'hF800) == 32'hF800) return THUMB_BL_LOW;
        return THUMB_UNDEFINED;
    endfunction

    function automatic vec_t model_decode(logic [31:0] w, bit thumb);
        vec_t v = '0;
        int t;
        if (!thumb) begin
            t = arm_class(w);
            v[F_COND] = bits(w, 28, 4);
            v[F_TYPE] = t;
            if (t != INSTR_BRANCH && t != INSTR_COPROCESSOR && t != INSTR_SWI) begin
                v[F_RD] = bits(w, 12, 4);  v[F_RN] = bits(w, 16, 4);
                v[F_RM] = bits(w, 0, 4);   v[F_IMM] = bits(w, 0, 12);
                v[F_SHT] = bits(w, 5, 2);  v[F_SHA] = bits(w, 7, 5);
                v[F_SHR] = bits(w, 4, 1);  v[F_SHRS] = bits(w, 8, 4);
            end
            if (t == INSTR_SINGLE_DT || t == INSTR_BLOCK_DT ||
                t == INSTR_HALFWORD_DT || t == INSTR_SINGLE_SWAP) begin
                v[F_ISM] = 1;
                v[F_ML] = bits(w, 20, 1);  v[F_MB] = bits(w, 22, 1);
                v[F_MP] = bits(w, 24, 1);  v[F_MU] = bits(w, 23, 1);
                v[F_MW] = bits(w, 21, 1);
            end
            if (t == INSTR_DATA_PROC) begin
                v[F_ALU] = bits(w, 21, 4);
                v[F_IMMEN] = bits(w, 25, 1);
            end
            if (t == INSTR_DATA_PROC || t == INSTR_MUL || t == INSTR_MUL_LONG)
                v[F_SETF] = bits(w, 20, 1);
            if (t == INSTR_SINGLE_DT) v[F_IMMEN] = 1 - bits(w, 25, 1);
            if (t == INSTR_HALFWORD_DT) v[F_IMMEN] = bits(w, 22, 1);
            if (t == INSTR_PSR_TRANSFER) begin
                v[F_PTR] = 1 - bits(w, 21, 1);
                v[F_PSP] = bits(w, 22, 1);
                v[F_PIM] = bits(w, 25, 1);
            end
            if (t == INSTR_BRANCH || t == INSTR_BRANCH_EX) v[F_ISB] = 1;
            if (t == INSTR_BRANCH) begin
                v[F_BL] = bits(w, 24, 1);
                v[F_BOFF] = bits(w, 0, 24);
            end
            if (t == INSTR_COPROCESSOR) begin
                if (bits(w, 25, 3) == 3'b110)
                    v[F_CPOP] = bits(w, 20, 1) != 0 ? CP_LDC : CP_STC;
                else if (bits(w, 4, 1) == 0)
                    v[F_CPOP] = CP_CDP;
                else
                    v[F_CPOP] = bits(w, 20, 1) != 0 ? CP_MRC : CP_MCR;
                v[F_CPN] = bits(w, 8, 4);   v[F_CPRD] = bits(w, 12, 4);
                v[F_CPRN] = bits(w, 16, 4); v[F_CPO1] = bits(w, 21, 3);
                v[F_CPO2] = bits(w, 5, 3);  v[F_CPL] = bits(w, 20, 1);
            end
        end else begin
            t = thumb_class(w & 32'hFFFF);
            v[F_TTYPE] = t;
            v[F_COND] = (t == THUMB_BRANCH_COND) ? bits(w, 8, 4) : 32'd14;
            if (t == THUMB_CMP_MOV_IMM || t == THUMB_PC_REL_LOAD ||
                t == THUMB_LOAD_STORE_SP || t == THUMB_GET_REL_ADDR ||
                t == THUMB_LOAD_STORE_MULT)
                v[F_TRD] = bits(w, 8, 3);
            else
                v[F_TRD] = bits(w, 0, 3);
            v[F_TRS] = bits(w, 3, 3);   v[F_TRN] = bits(w, 6, 3);
            v[F_TI8] = bits(w, 0, 8);   v[F_TO8] = bits(w, 0, 8);
            v[F_TI5] = bits(w, 6, 5);   v[F_TO11] = bits(w, 0, 11);
        end
        return v;
    endfunction

    task automatic step(bit r, bit f, bit s, bit v, bit t, logic [31:0] w);
        rst_n = r; flush = f; stall = s; instr_valid = v;
        thumb_mode = t; instruction = w; pc_in = pc_cnt;
        pc_cnt = pc_cnt + (t ? 32'd2 : 32'd4);
        if (r)
            st = '0;
        else if (f)
            st[F_VALID] = 0;
        else if (!s) begin
            st = model_decode(w, t);
            st[F_PC] = pc_in;
            st[F_VALID] = 32'(v);
        end
        q.push_back(st);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected snapshot per clock edge, compared mid-cycle.
    initial begin
        vec_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a = '0;
                a[F_COND] = 32'(condition);      a[F_TYPE] = 32'(instr_type);
                a[F_ALU] = 32'(alu_op);          a[F_RD] = 32'(rd);
                a[F_RN] = 32'(rn);               a[F_RM] = 32'(rm);
                a[F_IMM] = 32'(immediate);       a[F_IMMEN] = 32'(imm_en);
                a[F_SETF] = 32'(set_flags);      a[F_SHT] = 32'(shift_type);
                a[F_SHA] = 32'(shift_amount);    a[F_SHR] = 32'(shift_reg);
                a[F_SHRS] = 32'(shift_rs);       a[F_ISB] = 32'(is_branch);
                a[F_BL] = 32'(branch_link);      a[F_BOFF] = 32'(branch_offset);
                a[F_ISM] = 32'(is_memory);       a[F_ML] = 32'(mem_load);
                a[F_MB] = 32'(mem_byte);         a[F_MP] = 32'(mem_pre);
                a[F_MU] = 32'(mem_up);           a[F_MW] = 32'(mem_writeback);
                a[F_PTR] = 32'(psr_to_reg);      a[F_PSP] = 32'(psr_spsr);
                a[F_PIM] = 32'(psr_immediate);   a[F_CPOP] = 32'(cp_op);
                a[F_CPN] = 32'(cp_num);          a[F_CPRD] = 32'(cp_rd);
                a[F_CPRN] = 32'(cp_rn);          a[F_CPO1] = 32'(cp_opcode1);
                a[F_CPO2] = 32'(cp_opcode2);     a[F_CPL] = 32'(cp_load);
                a[F_TTYPE] = 32'(thumb_instr_type);
                a[F_TRD] = 32'(thumb_rd);        a[F_TRS] = 32'(thumb_rs);
                a[F_TRN] = 32'(thumb_rn);        a[F_TI8] = 32'(thumb_imm8);
                a[F_TO8] = 32'(thumb_offset8);   a[F_TI5] = 32'(thumb_imm5);
                a[F_TO11] = 32'(thumb_offset11); a[F_PC] = pc_out;
                a[F_VALID] = 32'(decode_valid);
                for (int i = 0; i < NF; i++) begin
                    checks++;
                    if (a[i] !== e[i]) begin
                        failures++;
                        $display("FAIL %s at %0t: got %0h expected %0h",
                                 fname[i], $time, a[i], e[i]);
                    end
                end
            end
        end
    end

    initial begin
        bit r, f, s, v, t;
        logic [31:0] w;
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 0, 32'hE0820001);
        foreach (arm_vec[i]) step(0, 0, 0, 1, 0, arm_vec[i]);
        foreach (thm_vec[i]) step(0, 0, 0, 1, 1, {16'hA5A5, thm_vec[i]});
        step(0, 0, 0, 1, 0, 32'hE0820001);
        step(0, 0, 1, 1, 0, 32'hEB000000);
        step(0, 0, 1, 1, 1, 32'h0000D000);
        step(0, 0, 1, 0, 0, 32'hE5D10000);
        step(0, 0, 0, 1, 0, 32'hE8910003);
        step(0, 1, 0, 1, 0, 32'hEF000000);
        step(0, 1, 1, 1, 0, 32'hEE000010);
        step(0, 0, 0, 1, 0, 32'hE1D100F0);
        step(1, 0, 0, 1, 0, 32'hE0000291);
        step(0, 0, 0, 1, 0, 32'hE0800291);
        step(0, 0, 0, 1, 1, 32'h0000F800);
        for (int k = 0; k < 500; k++) begin
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 5);
            s = ($urandom_range(0, 99) < 10);
            v = ($urandom_range(0, 99) < 85);
            t = 1'($urandom_range(0, 1));
            if (t || $urandom_range(0, 2) == 0)
                w = $urandom();
            else
                w = arm_vec[$urandom_range(0, 13)] ^ ($urandom() & 32'hF000F00F);
            step(r, f, s, v, t, w);
        end
        step(0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm7tdmi_decode.md
Name: arm7tdmi_decode

Overview:
- Pipeline decode stage of the ARM7TDMI core; sits between fetch and execute.
- Classifies one 32-bit ARM instruction or one 16-bit Thumb instruction (instruction[15:0]) per cycle.
- Extracts operand fields into registered outputs with one-cycle latency.
- Enumerated types (condition_t, instr_type_t, alu_op_t, shift_type_t, cp_op_t, thumb_instr_type_t) come from arm7tdmi_pkg.

Parameters:
- none

Ports:
- clk  input  1  clock; all outputs update on its rising edge.
- rst_n  input  1  synchronous reset, active-high: reset takes effect when rst_n=1 at a rising clk edge. The name is kept for codebase consistency; polarity and synchronicity are fixed as stated.
- instruction  input  32  fetched word; Thumb uses [15:0].
- pc_in  input  32  PC of the instruction.
- instr_valid, stall, flush, thumb_mode  input  1 each  fetch valid, pipeline hold, pipeline kill, Thumb state.
- condition  output  condition_t  ARM [31:28]; Thumb conditional branch [11:8]; other Thumb instructions AL.
- instr_type  output  instr_type_t  ARM class.
- alu_op  output  alu_op_t  [24:21].
- rd, rn, rm  output  4 each  [15:12], [19:16], [3:0].
- immediate  output  12  [11:0].
- imm_en, set_flags  output  1 each.
- shift_type  output  shift_type_t  [6:5].
- shift_amount  output  5  [11:7].
- shift_reg  output  1  [4].
- shift_rs  output  4  [11:8].
- is_branch, branch_link  output  1 each.
- branch_offset  output  24  [23:0].
- is_memory, mem_load, mem_byte, mem_pre, mem_up, mem_writeback  output  1 each.
- psr_to_reg, psr_spsr, psr_immediate  output  1 each.
- cp_op  output  cp_op_t.
- cp_num, cp_rd, cp_rn  output  4 each  [11:8], [15:12], [19:16].
- cp_opcode1, cp_opcode2  output  3 each  [23:21], [7:5].
- cp_load  output  1  [20].
- thumb_instr_type  output  thumb_instr_type_t.
- thumb_rd, thumb_rs, thumb_rn  output  3 each.
- thumb_imm8, thumb_offset8  output  8 each  [7:0].
- thumb_imm5  output  5  [10:6].
- thumb_offset11  output  11  [10:0].
- pc_out  output  32  registered pc_in.
- decode_valid  output  1  outputs hold a valid decode.

Behaviour:
- Reset (rst_n=1 at an edge): every output goes to 0; enumerated outputs go to encoding 0.
- Priority at each edge: reset > flush > stall > normal.
  - flush: decode_valid <= 0.
  - stall: all outputs hold.
  - normal: all outputs load the decode of the current inputs; decode_valid <= instr_valid.
- Latency: exactly one cycle.
- ARM classification, first match wins:
  1. [27:4]=0x12FFF1 -> INSTR_BRANCH_EX.
  2. [27:22]=000000 and [7:4]=1001 -> INSTR_MUL.
  3. [27:23]=00001 and [7:4]=1001 -> INSTR_MUL_LONG.
  4. [27:23]=00010, [21:20]=00, [11:4]=00001001 -> INSTR_SINGLE_SWAP.
  5. [27:25]=000, [7]=1, [4]=1, [6:5]!=00 -> INSTR_HALFWORD_DT.
  6. [27:26]=00, [24:23]=10, [20]=0 -> INSTR_PSR_TRANSFER.
  7. [27:26]=00 -> INSTR_DATA_PROC.
  8. 01 -> INSTR_SINGLE_DT.
  9. 100 -> INSTR_BLOCK_DT.
  10. 101 -> INSTR_BRANCH.
  11. 110 or [27:24]=1110 -> INSTR_COPROCESSOR.
  12. 1111 -> INSTR_SWI.
- ARM field rules:
  - set_flags=[20].
  - imm_en: data processing [25]; single DT ~[25]; halfword [22].
  - is_branch=1 for BRANCH and BRANCH_EX; branch_link=[24] for BRANCH only.
  - is_memory=1 for SINGLE_DT, BLOCK_DT, HALFWORD_DT, SINGLE_SWAP.
  - mem_load=[20], mem_byte=[22], mem_pre=[24], mem_up=[23], mem_writeback=[21].
  - psr_to_reg=1 when MRS ([21]=0); psr_spsr=[22]; psr_immediate=[25].
  - cp_op: [27:25]=110 -> CP_LDC if [20]=1, else CP_STC. [4]=0 -> CP_CDP. [4]=1 -> CP_MRC if [20]=1, else CP_MCR.
  - Fields not meaningful for the class are 0.
- Thumb classification (thumb_mode=1), on [15:11] and sub-bits:
  - 000xx (xx!=11) -> THUMB_SHIFT
  - 00011 -> THUMB_ALU_IMM (add/sub, register or imm3)
  - 001 -> THUMB_CMP_MOV_IMM
  - 010000 -> THUMB_ALU_REG
  - 010001 -> THUMB_ALU_HI (includes BX)
  - 01001 -> THUMB_PC_REL_LOAD
  - 0101 -> THUMB_LOAD_STORE_REG
  - 011 -> THUMB_LOAD_STORE_IMM
  - 1000 -> THUMB_LOAD_STORE_HW
  - 1001 -> THUMB_LOAD_STORE_SP
  - 1010 -> THUMB_GET_REL_ADDR
  - 10110000 -> THUMB_ADD_SP
  - 1011x10 -> THUMB_PUSH_POP
  - 1100 -> THUMB_LOAD_STORE_MULT
  - 11011111 -> THUMB_SWI
  - 1101 -> THUMB_BRANCH_COND
  - 11100 -> THUMB_BRANCH_UNCOND
  - 11110 -> THUMB_BL_HIGH
  - 11111 -> THUMB_BL_LOW
- Thumb field rules:
  - thumb_rd=[2:0], except formats with Rd at [10:8] (CMP_MOV_IMM, PC_REL_LOAD, LOAD_STORE_SP, GET_REL_ADDR, LOAD_STORE_MULT), where thumb_rd=[10:8].
  - thumb_rs=[5:3], thumb_rn=[8:6].
- In Thumb mode all ARM-only outputs are 0.
- In ARM mode thumb_instr_type and all thumb_* fields are 0.

Test Plan:
- Reset, then ARM 0xE0820001 with instr_valid=1 -> next edge: instr_type=INSTR_DATA_PROC, rd=0, rn=2, rm=1, alu_op=ADD, decode_valid=1.
- ARM class sweep, each with one-cycle latency:
  - 0xE0000291 -> INSTR_MUL
  - 0xE0800291 -> INSTR_MUL_LONG
  - 0xE1010091 -> INSTR_SINGLE_SWAP
  - 0xE1D100F0 -> INSTR_HALFWORD_DT
  - 0xE10F0000, 0xE129F000 -> INSTR_PSR_TRANSFER
  - 0xE12FFF10 -> INSTR_BRANCH_EX
  - 0xEB000000 -> INSTR_BRANCH with branch_link=1
  - 0xEF000000 -> INSTR_SWI
  - 0xEE000010 -> INSTR_COPROCESSOR with cp_op=CP_MCR
- Memory fields: 0xE5D10000 -> INSTR_SINGLE_DT, is_memory=1, mem_load=1, mem_byte=1, mem_pre=1, mem_up=1. 0xE8910003 -> INSTR_BLOCK_DT.
- Thumb sweep (thumb_mode=1):
  - 0x0148 -> THUMB_SHIFT, imm5=5
  - 0x3205 -> THUMB_CMP_MOV_IMM, rd=2
  - 0x1888 -> THUMB_ALU_IMM
  - 0x4700 -> THUMB_ALU_HI
  - 0xC800 -> THUMB_LOAD_STORE_MULT
  - 0xD000 -> THUMB_BRANCH_COND
  - 0xF000 -> THUMB_BL_HIGH
  - 0xF800 -> THUMB_BL_LOW
- stall=1 while instruction changes -> all outputs hold. flush=1 -> decode_valid=0 at next edge. Outputs resume on the first edge after stall/flush deassert.
- Assert rst_n=1 mid-stream -> all outputs 0 at the next edge; decoding resumes on the first edge with rst_n=0.
